// File: rtl/mem_ring_stop_if.sv
`default_nettype none
// =====================================================================
// mem_ring_stop_if : burst memory port between the ring stop and memory.
// Revision: 1.0
// =====================================================================
interface mem_ring_stop_if;
  logic        memReq;
  logic        memWrite;
  logic [27:0] memAddr;
  logic        memAck;
  logic [31:0] memWdata;
  logic        memWvalid;
  logic [31:0] memRdata;
  logic        memRvalid;

  modport master (
    output memReq, memWrite, memAddr, memWdata, memWvalid,
    input  memAck, memRdata, memRvalid
  );

  modport slave (
    input  memReq, memWrite, memAddr, memWdata, memWvalid,
    output memAck, memRdata, memRvalid
  );
endinterface
`default_nettype wire

// File: rtl/mem_ring_stop.sv
`default_nettype none
// =====================================================================
// mem_ring_stop : ring station turning address/write-data slots into
// in-order 8-word memory bursts. Define MEM_RING_STATS_EN for counters.
// Revision: 1.0
// =====================================================================
module mem_ring_stop #(
  parameter int unsigned CQ_DEPTH  = 4,
  parameter logic [3:0]  IDLE_DEST = 4'd0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     RingIn,
  input  logic [3:0]      SlotTypeIn,
  input  logic [3:0]      SourceIn,
  output logic [31:0]     RingOut,
  output logic [3:0]      SlotTypeOut,
  output logic [3:0]      SourceOut,
  output logic [31:0]     RDreturn,
  output logic [3:0]      RDdest,
  mem_ring_stop_if.master mem,
  output logic            overflow,
  output logic [15:0]     readCount,
  output logic [15:0]     writeCount
);
  localparam int unsigned     c_PW    = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
  localparam logic [c_PW:0]   c_FULL  = (c_PW + 1)'(CQ_DEPTH);
  localparam logic [3:0]      c_NULL  = 4'd7;
  localparam logic [3:0]      c_ADDR  = 4'd2;
  localparam logic [3:0]      c_WDATA = 4'd3;

  typedef struct packed {
    logic        isWrite;
    logic [3:0]  src;
    logic [27:0] addr;
    logic        sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WDATA = 2'd2, RDATA = 2'd3} state_t;

  state_t          r_state, w_nextState;
  cmd_t            r_cq [CQ_DEPTH];
  cmd_t            w_head;
  logic [c_PW-1:0] r_head, r_tail;
  logic [c_PW:0]   r_count;
  logic [31:0]     r_wbuf [2][8];
  logic            r_fillSel;
  logic [2:0]      r_wcnt;
  logic [1:0]      r_busy;
  logic [2:0]      r_beat;
  logic [3:0]      r_curSrc;
  logic            r_curSel;
  logic            r_overflow;
  logic [31:0]     r_ringOut, r_rdReturn;
  logic [3:0]      r_slotTypeOut, r_sourceOut, r_rdDest;

  logic w_isAddr, w_isWd, w_wrAddr, w_rdAddr, w_consume;
  logic w_pop, w_room, w_bufFree, w_wdAccept, w_push, w_wrPush, w_ovf, w_wdone;
  logic w_memReq, w_memWvalid;

  assign w_isAddr   = (SlotTypeIn == c_ADDR);
  assign w_isWd     = (SlotTypeIn == c_WDATA);
  assign w_wrAddr   = w_isAddr && (RingIn[31:28] == 4'b0000);
  assign w_rdAddr   = w_isAddr && ((RingIn[31:28] == 4'b0001) || (RingIn[31:28] == 4'b0011));
  assign w_consume  = w_wrAddr || w_rdAddr || w_isWd;

  // A pop in the same cycle frees a slot, so a full queue still accepts the push.
  assign w_head     = r_cq[r_head];
  assign w_pop      = (r_state == ISSUE) && mem.memAck;
  assign w_room     = (r_count != c_FULL) || w_pop;
  assign w_bufFree  = !r_busy[r_fillSel];
  assign w_wdAccept = w_isWd && w_bufFree;
  assign w_wrPush   = w_wrAddr && w_room && w_bufFree;
  assign w_push     = (w_rdAddr && w_room) || w_wrPush;
  assign w_ovf      = ((w_rdAddr || w_wrAddr) && !w_room) || (w_isWd && !w_bufFree) ||
                      (w_wrAddr && (!w_bufFree || (r_wcnt != 3'd0)));
  assign w_wdone    = (r_state == WDATA) && (r_beat == 3'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_memReq    = 1'b0;
    w_memWvalid = 1'b0;
    case (r_state)
      IDLE:    if (r_count != '0) w_nextState = ISSUE;
      ISSUE: begin
        w_memReq = 1'b1;
        if (mem.memAck) w_nextState = w_head.isWrite ? WDATA : RDATA;
      end
      WDATA: begin
        w_memWvalid = 1'b1;
        if (r_beat == 3'd7) w_nextState = IDLE;
      end
      RDATA:   if (mem.memRvalid && (r_beat == 3'd7)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push)     r_cq[r_tail] <= {w_wrAddr, SourceIn, RingIn[27:0], r_fillSel};
    if (w_wdAccept) r_wbuf[r_fillSel][r_wcnt] <= RingIn;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_fillSel     <= 1'b0;
      r_wcnt        <= 3'd0;
      r_busy        <= 2'b00;
      r_beat        <= 3'd0;
      r_curSrc      <= 4'd0;
      r_curSel      <= 1'b0;
      r_overflow    <= 1'b0;
      r_ringOut     <= 32'd0;
      r_slotTypeOut <= c_NULL;
      r_sourceOut   <= 4'd0;
      r_rdReturn    <= 32'd0;
      r_rdDest      <= IDLE_DEST;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head   <= r_head + 1'b1;
        r_curSrc <= w_head.src;
        r_curSel <= w_head.sel;
        r_beat   <= 3'd0;
      end else if ((r_state == WDATA) || ((r_state == RDATA) && mem.memRvalid)) begin
        r_beat <= r_beat + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wrAddr)        r_wcnt <= 3'd0;
      else if (w_wdAccept) r_wcnt <= r_wcnt + 1'b1;
      if (w_wrPush)        r_fillSel <= ~r_fillSel;
      // The buffer being drained and the one being handed out are never the same.
      if (w_wdone)         r_busy[r_curSel] <= 1'b0;
      if (w_wrPush)        r_busy[r_fillSel] <= 1'b1;
      if (w_ovf)           r_overflow <= 1'b1;
      r_slotTypeOut <= w_consume ? c_NULL : SlotTypeIn;
      r_ringOut     <= w_consume ? 32'd0  : RingIn;
      r_sourceOut   <= w_consume ? 4'd0   : SourceIn;
      if ((r_state == RDATA) && mem.memRvalid) begin
        r_rdReturn <= mem.memRdata;
        r_rdDest   <= r_curSrc;
      end else begin
        r_rdReturn <= 32'd0;
        r_rdDest   <= IDLE_DEST;
      end
    end
  end

  assign mem.memReq    = w_memReq;
  assign mem.memWrite  = w_head.isWrite;
  assign mem.memAddr   = w_head.addr;
  assign mem.memWvalid = w_memWvalid;
  assign mem.memWdata  = r_wbuf[r_curSel][r_beat];
  assign RingOut       = r_ringOut;
  assign SlotTypeOut   = r_slotTypeOut;
  assign SourceOut     = r_sourceOut;
  assign RDreturn      = r_rdReturn;
  assign RDdest        = r_rdDest;
  assign overflow      = r_overflow;

`ifdef MEM_RING_STATS_EN
  logic        w_rdone;
  logic [15:0] r_readCount, r_writeCount;
  assign w_rdone = (r_state == RDATA) && mem.memRvalid && (r_beat == 3'd7);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_readCount  <= 16'd0;
      r_writeCount <= 16'd0;
    end else begin
      if (w_rdone) r_readCount  <= r_readCount + 16'd1;
      if (w_wdone) r_writeCount <= r_writeCount + 16'd1;
    end
  end
  assign readCount  = r_readCount;
  assign writeCount = r_writeCount;
`else
  assign readCount  = 16'd0;
  assign writeCount = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_ring_stop.sv
`default_nettype none
// =====================================================================
// tb_mem_ring_stop : directed and randomized bench for mem_ring_stop.
// Revision: 1.0
// =====================================================================
module tb_mem_ring_stop;
  localparam logic [3:0] NULL_T = 4'd7, TOKEN_T = 4'd1, ADDR_T = 4'd2, WD_T = 4'd3;
  localparam logic [3:0] IDLE_D = 4'd0;

  typedef struct {
    bit               w;
    logic [3:0]       s;
    logic [27:0]      a;
    logic [7:0][31:0] d;
  } cmd_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] RingIn = 32'd0;
  logic [3:0]  SlotTypeIn = NULL_T;
  logic [3:0]  SourceIn = 4'd0;
  logic [31:0] RingOut, RDreturn;
  logic [3:0]  SlotTypeOut, SourceOut, RDdest;
  logic        overflow;
  logic [15:0] readCount, writeCount;

  int   nTests = 0;
  int   nFail  = 0;
  int   expRd  = 0;
  int   expWr  = 0;
  bit   statsEn;
  cmd_t model[$];

  mem_ring_stop_if memBus();

  mem_ring_stop dut (
    .clock(clock), .reset(reset),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .mem(memBus),
    .overflow(overflow), .readCount(readCount), .writeCount(writeCount)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic cmd_t mk(input bit w, input logic [3:0] s, input logic [27:0] a,
                              input logic [7:0][31:0] d);
    cmd_t c;
    c.w = w; c.s = s; c.a = a; c.d = d;
    return c;
  endfunction

  function automatic logic [7:0][31:0] rndData();
    logic [7:0][31:0] d;
    for (int i = 0; i < 8; i++) d[i] = $urandom;
    return d;
  endfunction

  // Drive one ring slot and check what the station forwards a cycle later.
  task automatic sendSlot(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    logic [3:0] code;
    bit consumed;
    code = d[31:28];
    consumed = (t == WD_T) || ((t == ADDR_T) && (code == 4'd0 || code == 4'd1 || code == 4'd3));
    SlotTypeIn = t; SourceIn = s; RingIn = d;
    step();
    if (consumed) begin
      check("slotConsumedType", 32'(SlotTypeOut), 32'(NULL_T));
      check("slotConsumedData", RingOut, 32'd0);
    end else begin
      check("slotPassType", 32'(SlotTypeOut), 32'(t));
      check("slotPassData", RingOut, d);
      check("slotPassSrc", 32'(SourceOut), 32'(s));
    end
    SlotTypeIn = NULL_T; SourceIn = 4'd0; RingIn = 32'd0;
  endtask

  task automatic sendCmd(input cmd_t c, input logic [3:0] rdCode);
    if (c.w) begin
      for (int i = 0; i < 8; i++) sendSlot(WD_T, c.s, c.d[i]);
      sendSlot(ADDR_T, c.s, {4'h0, c.a});
    end else begin
      sendSlot(ADDR_T, c.s, {rdCode, c.a});
    end
  endtask

  task automatic waitReq(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      if (memBus.memReq === 1'b1) ok = 1'b1;
      else begin step(); n++; end
    end
    if (!ok) check("memReqTimeout", 32'd0, 32'd1);
  endtask

  task automatic collectWrite(input logic [7:0][31:0] d);
    for (int i = 0; i < 8; i++) begin
      check("wvalid", 32'(memBus.memWvalid), 32'd1);
      check("wdata", memBus.memWdata, d[i]);
      check("reqLowInBurst", 32'(memBus.memReq), 32'd0);
      step();
    end
    check("wvalidEnd", 32'(memBus.memWvalid), 32'd0);
  endtask

  task automatic feedRead(input logic [3:0] src);
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) begin
        memBus.memRvalid = 1'b0;
        memBus.memRdata  = $urandom;
        step();
        check("rdDestGap", 32'(RDdest), 32'(IDLE_D));
        check("rdRetGap", RDreturn, 32'd0);
      end
      rd = $urandom;
      memBus.memRvalid = 1'b1;
      memBus.memRdata  = rd;
      step();
      memBus.memRvalid = 1'b0;
      check("rdReturn", RDreturn, rd);
      check("rdDest", 32'(RDdest), 32'(src));
    end
    step();
    check("rdDestEnd", 32'(RDdest), 32'(IDLE_D));
    check("rdRetEnd", RDreturn, 32'd0);
  endtask

  task automatic checkCounts();
    check("readCount", 32'(readCount), statsEn ? 32'(expRd) : 32'd0);
    check("writeCount", 32'(writeCount), statsEn ? 32'(expWr) : 32'd0);
  endtask

  task automatic serve(input cmd_t c, input int ackDelay);
    bit ok;
    waitReq(ok);
    if (ok) begin
      repeat (ackDelay) step();
      check("memReqHeld", 32'(memBus.memReq), 32'd1);
      check("memWrite", 32'(memBus.memWrite), 32'(c.w));
      check("memAddr", 32'(memBus.memAddr), 32'(c.a));
      memBus.memAck = 1'b1;
      step();
      memBus.memAck = 1'b0;
      if (c.w) begin collectWrite(c.d); expWr++; end
      else     begin feedRead(c.s);     expRd++; end
      checkCounts();
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    memBus.memAck = 1'b0;
    memBus.memRvalid = 1'b0;
    SlotTypeIn = NULL_T; SourceIn = 4'd0; RingIn = 32'd0;
    step(); step();
    reset = 1'b1;
    step();
    expRd = 0; expWr = 0;
    model.delete();
  endtask

  initial begin
    cmd_t c, a, b, x;
    logic [7:0][31:0] d;
    int nCmd, nWr;
    bit ok;
`ifdef MEM_RING_STATS_EN
    statsEn = 1'b1;
`else
    statsEn = 1'b0;
`endif
    memBus.memAck = 1'b0;
    memBus.memRvalid = 1'b0;
    memBus.memRdata = 32'd0;

    // Reset state
    step(); step();
    check("rstMemReq", 32'(memBus.memReq), 32'd0);
    check("rstWvalid", 32'(memBus.memWvalid), 32'd0);
    check("rstSlotType", 32'(SlotTypeOut), 32'(NULL_T));
    check("rstRingOut", RingOut, 32'd0);
    check("rstSourceOut", 32'(SourceOut), 32'd0);
    check("rstRdDest", 32'(RDdest), 32'(IDLE_D));
    check("rstRdReturn", RDreturn, 32'd0);
    check("rstOverflow", 32'(overflow), 32'd0);
    checkCounts();
    reset = 1'b1;
    step();

    // D read, source 3, ack after two cycles
    c = mk(1'b0, 4'd3, 28'h0000123, '0);
    sendCmd(c, 4'b0001);
    serve(c, 2);

    // Write burst from core 2 with data A0..A7
    for (int i = 0; i < 8; i++) d[i] = 32'hA0 + 32'(i);
    c = mk(1'b1, 4'd2, 28'h0000040, d);
    sendCmd(c, 4'b0000);
    serve(c, 1);

    // Write then read of the same line: write burst first
    a = mk(1'b1, 4'd4, 28'h0000010, rndData());
    b = mk(1'b0, 4'd5, 28'h0000010, '0);
    sendCmd(a, 4'b0000);
    sendCmd(b, 4'b0001);
    serve(a, 0);
    serve(b, 1);

    // Token and unknown address code pass through untouched
    sendSlot(TOKEN_T, 4'd6, $urandom);
    sendSlot(ADDR_T, 4'd7, {4'b0101, 28'($urandom)});
    repeat (4) step();
    check("passNoReq", 32'(memBus.memReq), 32'd0);
    check("passNoOvf", 32'(overflow), 32'd0);

    // Third write while both buffers are still pending
    a = mk(1'b1, 4'd1, 28'h0000100, rndData());
    b = mk(1'b1, 4'd2, 28'h0000200, rndData());
    x = mk(1'b1, 4'd3, 28'h0000300, rndData());
    sendCmd(a, 4'b0000);
    sendCmd(b, 4'b0000);
    check("twoWritesNoOvf", 32'(overflow), 32'd0);
    sendCmd(x, 4'b0000);
    check("thirdWriteOvf", 32'(overflow), 32'd1);
    serve(a, 1);
    serve(b, 0);
    check("ovfSticky", 32'(overflow), 32'd1);
    doReset();
    check("ovfCleared", 32'(overflow), 32'd0);

    // Reset in the middle of a read burst
    c = mk(1'b0, 4'd9, 28'h0000ABC, '0);
    sendCmd(c, 4'b0011);
    waitReq(ok);
    memBus.memAck = 1'b1;
    step();
    memBus.memAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memBus.memRvalid = 1'b1;
      memBus.memRdata = 32'h5000 + 32'(i);
      step();
      memBus.memRvalid = 1'b0;
      check("midRdDest", 32'(RDdest), 32'd9);
    end
    reset = 1'b0;
    #1;
    check("asyncRdDest", 32'(RDdest), 32'(IDLE_D));
    check("asyncRdReturn", RDreturn, 32'd0);
    step();
    reset = 1'b1;
    memBus.memRvalid = 1'b1;
    memBus.memRdata = 32'hDEAD;
    step();
    memBus.memRvalid = 1'b0;
    check("postRstRdDest", 32'(RDdest), 32'(IDLE_D));
    check("postRstRdReturn", RDreturn, 32'd0);
    check("postRstReadCount", 32'(readCount), 32'd0);
    repeat (3) step();
    check("postRstNoReq", 32'(memBus.memReq), 32'd0);
    expRd = 0; expWr = 0;

    // Full queue: a push in the pop cycle is accepted
    for (int i = 0; i < 4; i++) begin
      model.push_back(mk(1'b0, 4'(i + 1), 28'(i + 16), '0));
      sendCmd(model[i], 4'b0001);
    end
    waitReq(ok);
    model.push_back(mk(1'b0, 4'd5, 28'h0000055, '0));
    memBus.memAck = 1'b1;
    SlotTypeIn = ADDR_T; SourceIn = 4'd5; RingIn = {4'b0001, 28'h0000055};
    step();
    memBus.memAck = 1'b0;
    SlotTypeIn = NULL_T; SourceIn = 4'd0; RingIn = 32'd0;
    check("pushPopNoOvf", 32'(overflow), 32'd0);
    c = model.pop_front();
    feedRead(c.s);
    expRd++;
    while (model.size() > 0) begin
      c = model.pop_front();
      serve(c, $urandom_range(0, 3));
    end

    // Randomized batches against the command-queue model
    for (int batch = 0; batch < 8; batch++) begin
      nCmd = $urandom_range(1, 4);
      nWr = 0;
      for (int k = 0; k < nCmd; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 3))
            0: sendSlot(TOKEN_T, 4'($urandom), $urandom);
            1: sendSlot(NULL_T, 4'($urandom), $urandom);
            2: sendSlot(ADDR_T, 4'($urandom), {4'($urandom_range(4, 15)), 28'($urandom)});
            default: sendSlot(4'($urandom_range(8, 15)), 4'($urandom), $urandom);
          endcase
        end
        c = mk((nWr < 2) && ($urandom_range(0, 1) == 1), 4'($urandom), 28'($urandom), rndData());
        if (c.w) nWr++;
        model.push_back(c);
        sendCmd(c, ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b0001);
      end
      while (model.size() > 0) begin
        c = model.pop_front();
        serve(c, $urandom_range(0, 3));
      end
      check("rndNoOvf", 32'(overflow), 32'd0);
    end

    // Queue overflow: fifth command with four waiting
    for (int i = 0; i < 5; i++) begin
      sendSlot(ADDR_T, 4'd1, {4'b0001, 28'(i)});
      if (i == 3) check("fullNoOvf", 32'(overflow), 32'd0);
    end
    check("fullOvf", 32'(overflow), 32'd1);
    doReset();

    // Write address after a partial line
    for (int i = 0; i < 3; i++) sendSlot(WD_T, 4'd2, $urandom);
    check("partialNoOvf", 32'(overflow), 32'd0);
    sendSlot(ADDR_T, 4'd2, {4'h0, 28'h0000777});
    check("partialOvf", 32'(overflow), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
`default_nettype wire
